div_rate_monitor: RTL and testbench
===================================

// Module: div_rate_monitor
// PURPOSE
//  Downstream checker for the programmable clock divider. Takes the divider's
//  output and the same 2-bit rate select that drives the divider. Measures the
//  divided-clock period in clk cycles and checks it against the expected value.
//  Reports lock, period, edge count and a sticky rate error for board debug and
//  for self-check in simulation.
// PARAMETERS
//  CNT_W        8   period counter width; counter saturates at 2**CNT_W-1
//  EDGE_CNT_W  16   width of the rising-edge counter
//  LOCK_EDGES   2   consecutive matching periods required before locked=1
// PORTS
//  clk         in   1           system clock; same clock that drives the divider
//  rst         in   1           synchronous, active-high reset
//  x           in   2           rate select, shared with the divider
//  clk_div     in   1           divider output, synchronous to clk
//  period      out  CNT_W       last measured period, in clk cycles
//  period_vld  out  1           1-cycle pulse when period updates
//  locked      out  1           LOCK_EDGES consecutive periods have matched
//  rate_err    out  1           sticky: mismatch or timeout seen
//  edge_count  out  EDGE_CNT_W  count of clk_div rising edges, wraps
//  err_clr     in   1           present only when RATE_ERR_CLR_EN is defined
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; cnt=0; s1=s2=0; x_q=0.
//  - Sampling: s1<=clk_div, s2<=s1. rise = s1 & ~s2. x_q<=x every cycle.
//  - Expected period: exp = 4 << x, giving 4, 8, 16 or 32 cycles.
//  - FSM:
//    - IDLE: the cycle after rst is released, go to SYNC.
//    - SYNC: wait for rise. On rise: cnt<=1, go to MEAS. No period reported.
//    - MEAS: cnt increments by 1 each cycle.
//      - On rise: period<=cnt, period_vld<=1, cnt<=1.
//      - If cnt==exp: streak increments, saturating at LOCK_EDGES.
//        locked<=1 once streak reaches LOCK_EDGES.
//      - Otherwise: rate_err<=1, locked<=0, streak<=0. Stay in MEAS.
//  - Timeout: cnt reaching 2**CNT_W-1 in MEAS sets rate_err<=1 and locked<=0,
//    and the FSM goes to SYNC.
//  - Latency: all outputs are registered. period_vld is high in the cycle after
//    the clk edge at which rise is true.
//  - Rate change: x != x_q forces SYNC, locked<=0, streak<=0, cnt<=0.
//    No error is flagged for the partial period (blanking).
//    If a rate change and a rise occur in the same cycle, the change wins:
//    no period is reported, but edge_count still increments.
//  - edge_count increments on every rise in SYNC or MEAS and wraps to 0.
//  - Reset mid-measurement returns every register to its reset value on the
//    next clk edge.
// CONFIGURATION
//  RATE_ERR_CLR_EN defined:
//    - err_clr port exists. err_clr=1 clears rate_err on the next edge.
//    - A new error in the same cycle wins: rate_err stays 1.
//  RATE_ERR_CLR_EN undefined:
//    - No err_clr port. rate_err clears only on rst.
// TESTING
//  T1 rst, divider with x=00 -> period_vld every 4 cycles, period=4;
//     locked=1 at the 2nd pulse; rate_err=0.
//  T2 x=11 from reset -> period=32, locked=1, edge_count increments once per
//     32 cycles.
//  T3 x 00->10 mid-run -> locked=0 next cycle, rate_err stays 0;
//     relocks with period=16.
//  T4 drive clk_div with period 6 at x=00 -> period=6, rate_err=1, locked=0.
//     With RATE_ERR_CLR_EN: pulse err_clr -> rate_err=0, then re-sets on the
//     next bad period.
//  T5 hold clk_div low for 300 cycles in MEAS, CNT_W=8 -> rate_err=1 when cnt
//     reaches 255, state=SYNC.
//  T6 assert rst mid-MEAS -> all outputs 0 next cycle; lock resumes normally
//     after release.

Source files
------------

// File: rtl/div_rate_monitor.sv
// -----------------------------------------------------------------------------
// div_rate_monitor
//
// Downstream checker for the programmable clock divider. Measures the period of
// the divided clock in i_clk cycles, compares it with the period implied by the
// shared rate select (4 << x), and reports lock, last period, rising-edge count
// and a sticky rate error.
//
// Optional feature: define RATE_ERR_CLR_EN to add the i_err_clr port, which
// clears the sticky rate error (a new error in the same cycle takes priority).
// Without the macro, o_rate_err clears only on i_rst.
//
// Ports
//   i_clk          system clock, same clock that drives the divider
//   i_rst          synchronous, active-high reset
//   i_x            rate select shared with the divider
//   i_clk_div      divider output, synchronous to i_clk
//   i_err_clr      clear sticky rate error (RATE_ERR_CLR_EN only)
//   o_period       last measured period in i_clk cycles
//   o_period_vld   one-cycle pulse when o_period updates
//   o_locked       LOCK_EDGES consecutive periods have matched
//   o_rate_err     sticky: period mismatch or timeout seen
//   o_edge_count   count of i_clk_div rising edges, wraps
// -----------------------------------------------------------------------------
module div_rate_monitor #(
   parameter int CNT_W      = 8,
   parameter int EDGE_CNT_W = 16,
   parameter int LOCK_EDGES = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [1:0]            i_x,
   input  logic                  i_clk_div,
`ifdef RATE_ERR_CLR_EN
   input  logic                  i_err_clr,
`endif
   output logic [CNT_W-1:0]      o_period,
   output logic                  o_period_vld,
   output logic                  o_locked,
   output logic                  o_rate_err,
   output logic [EDGE_CNT_W-1:0] o_edge_count
);

   localparam int STREAK_W = $clog2(LOCK_EDGES + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LOCK_EDGES);

   typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_MEAS} state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic                  r_s1;
   logic                  r_s2;
   logic [1:0]            r_x_q;
   logic [CNT_W-1:0]      r_cnt;
   logic [STREAK_W-1:0]   r_streak;
   logic [CNT_W-1:0]      r_period;
   logic                  r_period_vld;
   logic                  r_locked;
   logic                  r_rate_err;
   logic [EDGE_CNT_W-1:0] r_edge_count;

   logic                  w_rise;
   logic                  w_rate_chg;
   logic                  w_cnt_max;
   logic [CNT_W-1:0]      w_exp;
   logic [STREAK_W-1:0]   w_streak_inc;

   logic [CNT_W-1:0]      w_cnt_nxt;
   logic [STREAK_W-1:0]   w_streak_nxt;
   logic [CNT_W-1:0]      w_period_nxt;
   logic                  w_period_vld_nxt;
   logic                  w_locked_nxt;
   logic                  w_err_set;
   logic                  w_rate_err_nxt;
   logic [EDGE_CNT_W-1:0] w_edge_count_nxt;

   assign w_rise       = r_s1 & ~r_s2;
   assign w_rate_chg   = (i_x != r_x_q);
   assign w_cnt_max    = (r_cnt == {CNT_W{1'b1}});
   // x_q equals x whenever a period is actually judged (a change forces SYNC)
   assign w_exp        = CNT_W'(4) << r_x_q;
   assign w_streak_inc = (r_streak == STREAK_MAX) ? r_streak : r_streak + 1'b1;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: w_state_nxt = ST_SYNC;
         ST_SYNC: begin
            if (!w_rate_chg && w_rise) w_state_nxt = ST_MEAS;
         end
         ST_MEAS: begin
            if (w_rate_chg)                w_state_nxt = ST_SYNC;
            else if (!w_rise && w_cnt_max) w_state_nxt = ST_SYNC;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      w_cnt_nxt        = r_cnt;
      w_streak_nxt     = r_streak;
      w_period_nxt     = r_period;
      w_period_vld_nxt = 1'b0;
      w_locked_nxt     = r_locked;
      w_err_set        = 1'b0;
      w_edge_count_nxt = r_edge_count;

      // Edges are counted even when a rate change blanks the measurement
      if ((r_state == ST_SYNC || r_state == ST_MEAS) && w_rise)
         w_edge_count_nxt = r_edge_count + 1'b1;

      case (r_state)
         ST_SYNC: begin
            if (w_rate_chg) begin
               w_cnt_nxt    = '0;
               w_streak_nxt = '0;
               w_locked_nxt = 1'b0;
            end else if (w_rise) begin
               w_cnt_nxt = CNT_W'(1);
            end
         end
         ST_MEAS: begin
            if (w_rate_chg) begin
               w_cnt_nxt    = '0;
               w_streak_nxt = '0;
               w_locked_nxt = 1'b0;
            end else if (w_rise) begin
               w_period_nxt     = r_cnt;
               w_period_vld_nxt = 1'b1;
               w_cnt_nxt        = CNT_W'(1);
               if (r_cnt == w_exp) begin
                  w_streak_nxt = w_streak_inc;
                  w_locked_nxt = r_locked | (w_streak_inc == STREAK_MAX);
               end else begin
                  w_streak_nxt = '0;
                  w_locked_nxt = 1'b0;
                  w_err_set    = 1'b1;
               end
            end else if (w_cnt_max) begin
               // Divided clock stalled: give up and resynchronise
               w_cnt_nxt    = '0;
               w_streak_nxt = '0;
               w_locked_nxt = 1'b0;
               w_err_set    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: ;
      endcase

`ifdef RATE_ERR_CLR_EN
      w_rate_err_nxt = w_err_set | (r_rate_err & ~i_err_clr);
`else
      w_rate_err_nxt = w_err_set | r_rate_err;
`endif
   end

   // Datapath and output registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1         <= 1'b0;
         r_s2         <= 1'b0;
         r_x_q        <= 2'b00;
         r_cnt        <= '0;
         r_streak     <= '0;
         r_period     <= '0;
         r_period_vld <= 1'b0;
         r_locked     <= 1'b0;
         r_rate_err   <= 1'b0;
         r_edge_count <= '0;
      end else begin
         r_s1         <= i_clk_div;
         r_s2         <= r_s1;
         r_x_q        <= i_x;
         r_cnt        <= w_cnt_nxt;
         r_streak     <= w_streak_nxt;
         r_period     <= w_period_nxt;
         r_period_vld <= w_period_vld_nxt;
         r_locked     <= w_locked_nxt;
         r_rate_err   <= w_rate_err_nxt;
         r_edge_count <= w_edge_count_nxt;
      end
   end

   assign o_period     = r_period;
   assign o_period_vld = r_period_vld;
   assign o_locked     = r_locked;
   assign o_rate_err   = r_rate_err;
   assign o_edge_count = r_edge_count;

endmodule

// File: tb/tb_div_rate_monitor.sv
// -----------------------------------------------------------------------------
// tb_div_rate_monitor
//
// Directed bench for div_rate_monitor. The bench plays the divider itself: a
// simple generator advanced once per clock produces i_clk_div with a chosen
// period (high for the first half). Expected values are hand-derived from the
// rate select and the generator period.
// -----------------------------------------------------------------------------
module tb_div_rate_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  x;
   logic        clk_div;
`ifdef RATE_ERR_CLR_EN
   logic        err_clr;
`endif
   logic [7:0]  period;
   logic        period_vld;
   logic        locked;
   logic        rate_err;
   logic [15:0] edge_count;

   int tests = 0;
   int fails = 0;

   bit gen_en  = 1'b0;
   int gen_per = 4;
   int gen_cnt = 0;
   int n;
   int vld_seen;

   always #5 clk = ~clk;

   div_rate_monitor #(
      .CNT_W      (8),
      .EDGE_CNT_W (16),
      .LOCK_EDGES (2)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_x          (x),
      .i_clk_div    (clk_div),
`ifdef RATE_ERR_CLR_EN
      .i_err_clr    (err_clr),
`endif
      .o_period     (period),
      .o_period_vld (period_vld),
      .o_locked     (locked),
      .o_rate_err   (rate_err),
      .o_edge_count (edge_count)
   );

   // One clock step; outputs are observed 1 time unit after the edge, and the
   // divider model advances at the same point.
   task automatic tick();
      @(posedge clk);
      #1;
      if (gen_en) begin
         gen_cnt = (gen_cnt + 1) % gen_per;
         clk_div = (gen_cnt < gen_per / 2);
      end
   endtask

   // Next tick drives clk_div high (start of a divided period)
   task automatic gen_start(input int per);
      gen_per = per;
      gen_cnt = per - 1;
      gen_en  = 1'b1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_vld(input string tag, input int budget, output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (period_vld !== 1'b1 && cycles < budget);
      check({tag, "_vld"}, {31'd0, period_vld}, 32'd1);
   endtask

   task automatic do_reset(input logic [1:0] xv);
      gen_en  = 1'b0;
      clk_div = 1'b0;
      x       = xv;
      rst     = 1'b1;
      tick();
      tick();
      rst     = 1'b0;
      tick();
   endtask

   initial begin
      rst     = 1'b1;
      x       = 2'b00;
      clk_div = 1'b0;
`ifdef RATE_ERR_CLR_EN
      err_clr = 1'b0;
`endif

      // ---- T1: reset state, then x=00 with a period-4 divider ----
      tick(); tick(); tick();
      check("rst_period",     {24'd0, period},     32'd0);
      check("rst_vld",        {31'd0, period_vld}, 32'd0);
      check("rst_locked",     {31'd0, locked},     32'd0);
      check("rst_rate_err",   {31'd0, rate_err},   32'd0);
      check("rst_edge_count", {16'd0, edge_count}, 32'd0);
      rst = 1'b0;
      tick();
      gen_start(4);
      wait_vld("t1_p1", 20, n);
      check("t1_p1_period", {24'd0, period},     32'd4);
      check("t1_p1_locked", {31'd0, locked},     32'd0);
      check("t1_p1_edges",  {16'd0, edge_count}, 32'd2);
      check("t1_p1_err",    {31'd0, rate_err},   32'd0);
      tick();
      check("t1_vld_pulse", {31'd0, period_vld}, 32'd0);
      wait_vld("t1_p2", 20, n);
      check("t1_spacing",   n,                   32'd3);
      check("t1_p2_period", {24'd0, period},     32'd4);
      check("t1_p2_locked", {31'd0, locked},     32'd1);
      check("t1_p2_edges",  {16'd0, edge_count}, 32'd3);
      check("t1_p2_err",    {31'd0, rate_err},   32'd0);

      // ---- T3: rate change 00 -> 10 while locked ----
      x       = 2'b10;
      gen_per = 16;
      gen_cnt = 8;
      tick();
      check("t3_unlock",    {31'd0, locked},     32'd0);
      check("t3_no_err",    {31'd0, rate_err},   32'd0);
      check("t3_no_vld",    {31'd0, period_vld}, 32'd0);
      wait_vld("t3_p1", 60, n);
      check("t3_p1_period", {24'd0, period},     32'd16);
      check("t3_p1_locked", {31'd0, locked},     32'd0);
      check("t3_p1_err",    {31'd0, rate_err},   32'd0);
      wait_vld("t3_p2", 40, n);
      check("t3_spacing",   n,                   32'd16);
      check("t3_p2_period", {24'd0, period},     32'd16);
      check("t3_p2_locked", {31'd0, locked},     32'd1);
      check("t3_p2_err",    {31'd0, rate_err},   32'd0);

      // ---- T2: x=11 from reset, period 32 ----
      do_reset(2'b11);
      check("t2_rst_locked", {31'd0, locked},     32'd0);
      gen_start(32);
      wait_vld("t2_p1", 100, n);
      check("t2_p1_period", {24'd0, period},     32'd32);
      check("t2_p1_locked", {31'd0, locked},     32'd0);
      check("t2_p1_edges",  {16'd0, edge_count}, 32'd2);
      wait_vld("t2_p2", 40, n);
      check("t2_spacing",   n,                   32'd32);
      check("t2_p2_period", {24'd0, period},     32'd32);
      check("t2_p2_locked", {31'd0, locked},     32'd1);
      check("t2_p2_edges",  {16'd0, edge_count}, 32'd3);
      check("t2_p2_err",    {31'd0, rate_err},   32'd0);

      // ---- T4: wrong period (6) at x=00 ----
      do_reset(2'b00);
      gen_start(6);
      wait_vld("t4_p1", 30, n);
      check("t4_p1_period", {24'd0, period},   32'd6);
      check("t4_p1_err",    {31'd0, rate_err}, 32'd1);
      check("t4_p1_locked", {31'd0, locked},   32'd0);
`ifdef RATE_ERR_CLR_EN
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("t4_clr",       {31'd0, rate_err}, 32'd0);
      // Clear held across the next bad period: the new error must win
      err_clr = 1'b1;
      wait_vld("t4_p2", 20, n);
      check("t4_p2_period", {24'd0, period},   32'd6);
      check("t4_reset_err", {31'd0, rate_err}, 32'd1);
      err_clr = 1'b0;
`endif
      // Fix the divider to period 4: relocks, but the error stays sticky
      gen_per = 4;
      wait_vld("t4_p3", 20, n);
      wait_vld("t4_p4", 20, n);
      check("t4_fix_period", {24'd0, period},   32'd4);
      check("t4_fix_locked", {31'd0, locked},   32'd1);
      check("t4_sticky_err", {31'd0, rate_err}, 32'd1);

      // ---- T5: divider stalls low in MEAS -> timeout at cnt=255 ----
      do_reset(2'b00);
      gen_start(4);
      wait_vld("t5_p1", 20, n);
      wait_vld("t5_p2", 20, n);
      check("t5_locked", {31'd0, locked}, 32'd1);
      gen_en   = 1'b0;
      clk_div  = 1'b0;
      vld_seen = 0;
      for (int i = 0; i < 254; i++) begin
         tick();
         if (period_vld === 1'b1) vld_seen++;
      end
      check("t5_pre_err",    {31'd0, rate_err}, 32'd0);
      check("t5_pre_locked", {31'd0, locked},   32'd1);
      tick();
      check("t5_timeout_err",    {31'd0, rate_err}, 32'd1);
      check("t5_timeout_locked", {31'd0, locked},   32'd0);
      for (int i = 0; i < 45; i++) begin
         tick();
         if (period_vld === 1'b1) vld_seen++;
      end
      check("t5_no_vld", vld_seen, 32'd0);
      // Back in SYNC: the first reported period after restart is a clean 4
      gen_start(4);
      wait_vld("t5_p3", 20, n);
      check("t5_resync_period", {24'd0, period}, 32'd4);

      // ---- T6: reset asserted mid-measurement ----
      do_reset(2'b00);
      gen_start(4);
      wait_vld("t6_p1", 20, n);
      wait_vld("t6_p2", 20, n);
      check("t6_pre_locked", {31'd0, locked}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_rst_period", {24'd0, period},     32'd0);
      check("t6_rst_vld",    {31'd0, period_vld}, 32'd0);
      check("t6_rst_locked", {31'd0, locked},     32'd0);
      check("t6_rst_err",    {31'd0, rate_err},   32'd0);
      check("t6_rst_edges",  {16'd0, edge_count}, 32'd0);
      wait_vld("t6_p3", 20, n);
      check("t6_p3_period", {24'd0, period},     32'd4);
      check("t6_p3_locked", {31'd0, locked},     32'd0);
      check("t6_p3_edges",  {16'd0, edge_count}, 32'd2);
      wait_vld("t6_p4", 20, n);
      check("t6_p4_locked", {31'd0, locked},   32'd1);
      check("t6_p4_err",    {31'd0, rate_err}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
